// File: rtl/bconv3x3_engine.sv
// Binarized 3x3 convolution stage: builds a sliding 3x3 window over a raster
// 1-bit pixel stream with two line buffers, then XNOR-popcounts the window
// against a 9-bit kernel and thresholds the match count.
module bconv3x3_engine #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pix_valid,
  input  logic          pix_in,
  input  logic [8:0]    weights,
  input  logic [3:0]    threshold,
  output logic          out_valid,
  output logic          out_bit,
  output logic [AW-1:0] out_rowaddr,
  output logic [AW-1:0] out_coladdr,
  output logic          frame_done
);

  // Raster position counters
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;
  logic [AW-1:0] w_row_nxt;
  logic [AW-1:0] w_col_nxt;
  logic          w_last;
  logic          w_win_valid;

  // Line buffers (lb0 = two rows back, lb1 = one row back) and window
  logic [IMG_W-1:0] r_lb0;
  logic [IMG_W-1:0] r_lb1;
  logic [8:0]       r_win;
  logic [8:0]       w_win_nxt;

  // Stage-1 control
  logic          r_s1_valid;
  logic          r_s1_last;
  logic [AW-1:0] r_s1_row;
  logic [AW-1:0] r_s1_col;

  // Stage-2 compute
  logic [8:0] w_xnor;
  logic [3:0] w_matches;

  // Effective position of the pixel presented this cycle; start forces (0,0)
  always_comb begin
    w_row       = start ? '0 : r_row;
    w_col       = start ? '0 : r_col;
    w_last      = (w_row == AW'(IMG_H - 1)) && (w_col == AW'(IMG_W - 1));
    w_win_valid = pix_valid && (w_row >= AW'(2)) && (w_col >= AW'(2));
    w_row_nxt   = w_row;
    w_col_nxt   = w_col;
    if (w_last) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (w_col == AW'(IMG_W - 1)) begin
      w_row_nxt = w_row + AW'(1);
      w_col_nxt = '0;
    end else begin
      w_col_nxt = w_col + AW'(1);
    end
  end

  // Next window: shift each row left, feed the new right column
  always_comb begin
    w_win_nxt = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_win_nxt[3*i+0] = r_win[3*i+1];
      w_win_nxt[3*i+1] = r_win[3*i+2];
    end
    w_win_nxt[2] = r_lb0[w_col];
    w_win_nxt[5] = r_lb1[w_col];
    w_win_nxt[8] = pix_in;
  end

  // Position counters advance on each accepted pixel; start clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (pix_valid) begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
    end else if (start) begin
      r_row <= '0;
      r_col <= '0;
    end
  end

  // Line buffers and window: unreset storage, gated by valid bits downstream
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_win        <= w_win_nxt;
      r_lb0[w_col] <= r_lb1[w_col];
      r_lb1[w_col] <= pix_in;
    end
  end

  // Stage 1: window valid flag, result address and end-of-frame marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_row   <= '0;
      r_s1_col   <= '0;
    end else begin
      r_s1_valid <= w_win_valid;
      if (w_win_valid) begin
        r_s1_row  <= w_row - AW'(2);
        r_s1_col  <= w_col - AW'(2);
        r_s1_last <= w_last;
      end
    end
  end

  // XNOR-popcount of the stage-1 window against the kernel
  always_comb begin
    w_xnor    = ~(r_win ^ weights);
    w_matches = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      w_matches = w_matches + 4'(w_xnor[k]);
    end
  end

  // Stage 2: thresholded result and write strobe; data holds between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_bit     <= 1'b0;
      out_rowaddr <= '0;
      out_coladdr <= '0;
      frame_done  <= 1'b0;
    end else begin
      out_valid  <= r_s1_valid;
      frame_done <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        out_bit     <= (w_matches >= threshold);
        out_rowaddr <= r_s1_row;
        out_coladdr <= r_s1_col;
      end
    end
  end

endmodule
